// File: rtl/issue_ctrl_if.sv
// Uop types shared by the pipe, and the issue controller's decode/wb/mem/control bundle.
// The pipe stages drive through the master modport; issue_ctrl sits on the slave side.
package Uop;
  typedef logic [29:0] iaddr_t;
  typedef logic [4:0]  reg_t;

  typedef enum logic [2:0] {
    EX_NONE    = 3'd0,
    EX_ILLEGAL = 3'd1,
    EX_ALIGN   = 3'd2,
    EX_MEM     = 3'd3,
    EX_ECALL   = 3'd4
  } ex_t;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_LSU = 2'd2,
    FU_BRU = 2'd3
  } fu_t;

  typedef struct packed {
    fu_t  fu;
    reg_t rd;
    reg_t rs1;
    reg_t rs2;
    logic imm_valid;
    ex_t  ex;
  } dec_t;
endpackage

interface issue_ctrl_if;
  import Uop::*;

  logic     dec_valid;
  dec_t     dec_uop;
  iaddr_t   dec_pc;
  logic     wb_valid;
  reg_t     wb_rd;
  logic     mem_valid;
  ex_t      mem_ex;
  iaddr_t   mem_pc;
  logic     issue;
  logic     stall;
  logic     flush;
  logic     redirect_valid;
  iaddr_t   redirect_pc;
  iaddr_t   exc_pc;
  ex_t      exc_cause;

  modport master (
    output dec_valid, dec_uop, dec_pc, wb_valid, wb_rd, mem_valid, mem_ex, mem_pc,
    input  issue, stall, flush, redirect_valid, redirect_pc, exc_pc, exc_cause
  );

  modport slave (
    input  dec_valid, dec_uop, dec_pc, wb_valid, wb_rd, mem_valid, mem_ex, mem_pc,
    output issue, stall, flush, redirect_valid, redirect_pc, exc_pc, exc_cause
  );
endinterface

// File: rtl/issue_ctrl.sv
// In-order issue/hazard controller: per-register in-flight scoreboard, RAW/saturation stalls,
// and the memory-stage exception flush -> trap redirect -> fetch refill sequence.
module issue_ctrl #(
  parameter int          CNT_W         = 2,
  parameter int          REFILL_CYCLES = 2,
  parameter logic [29:0] TRAP_VEC      = 30'h10
) (
  input logic        clk,
  input logic        rst,
  issue_ctrl_if.slave io
);
  import Uop::*;

  localparam int               RF_W        = $clog2(REFILL_CYCLES) + 1;
  localparam logic [RF_W-1:0]  REFILL_INIT = RF_W'(REFILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {RUN, FLUSH, REFILL} state_t;

  state_t                      state_q, state_d;
  logic [RF_W-1:0]             refill_q, refill_d;
  logic [31:0][CNT_W-1:0]      cnt_q, cnt_d;
  iaddr_t                      exc_pc_q, exc_pc_d;
  ex_t                         exc_cause_q, exc_cause_d;

  dec_t uop;
  logic rs1_haz, rs2_haz, sat_haz, hazard, dec_exc, mem_exc, count_rd;
  logic issue, stall;

  always_comb begin
    state_d     = state_q;
    refill_d    = refill_q;
    cnt_d       = cnt_q;
    exc_pc_d    = exc_pc_q;
    exc_cause_d = exc_cause_q;

    uop     = io.dec_uop;
    // A count of 1 retiring this cycle is forwarded by the regfile write-through.
    rs1_haz = (uop.rs1 != '0) && (cnt_q[uop.rs1] != '0) &&
              !((cnt_q[uop.rs1] == CNT_ONE) && io.wb_valid && (io.wb_rd == uop.rs1));
    rs2_haz = !uop.imm_valid && (uop.rs2 != '0) && (cnt_q[uop.rs2] != '0) &&
              !((cnt_q[uop.rs2] == CNT_ONE) && io.wb_valid && (io.wb_rd == uop.rs2));
    sat_haz = (uop.rd != '0) && (cnt_q[uop.rd] == CNT_MAX);
    hazard  = rs1_haz || rs2_haz || sat_haz;
    dec_exc = (uop.ex != EX_NONE);
    mem_exc = io.mem_valid && (io.mem_ex != EX_NONE);

    // Decode-excepting uops flow on as hazard-free bubbles that never claim their rd.
    issue    = (state_q == RUN) && io.dec_valid && !mem_exc && (dec_exc || !hazard);
    count_rd = issue && !dec_exc && (uop.rd != '0);
    stall    = (io.dec_valid && !issue) || (state_q != RUN);

    case (state_q)
      RUN: begin
        for (int r = 1; r < 32; r++) begin
          cnt_d[r] = cnt_q[r]
                   + CNT_W'(count_rd && (uop.rd == 5'(r)))
                   - CNT_W'(io.wb_valid && (io.wb_rd == 5'(r)) && (cnt_q[r] != '0));
        end
        if (mem_exc) begin
          state_d     = FLUSH;
          exc_pc_d    = io.mem_pc;
          exc_cause_d = io.mem_ex;
        end
      end
      FLUSH: begin
        cnt_d    = '0;
        refill_d = REFILL_INIT;
        state_d  = REFILL;
      end
      REFILL: begin
        if (refill_q == '0) state_d = RUN;
        else                refill_d = refill_q - 1'b1;
      end
      default: state_d = RUN;
    endcase
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      refill_q    <= '0;
      cnt_q       <= '0;
      exc_pc_q    <= '0;
      exc_cause_q <= EX_NONE;
    end else begin
      if ((state_q == RUN) && io.wb_valid && (io.wb_rd != '0))
        assert (cnt_q[io.wb_rd] != '0);
      state_q     <= state_d;
      refill_q    <= refill_d;
      cnt_q       <= cnt_d;
      exc_pc_q    <= exc_pc_d;
      exc_cause_q <= exc_cause_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{io.dec_pc, uop.fu};

  assign io.issue          = issue;
  assign io.stall          = stall;
  assign io.flush          = (state_q == FLUSH);
  assign io.redirect_valid = (state_q == FLUSH);
  assign io.redirect_pc    = TRAP_VEC;
  assign io.exc_pc         = exc_pc_q;
  assign io.exc_cause      = exc_cause_q;
endmodule
